// File: rtl/word_byte_serializer.sv
// word_byte_serializer: emits a registered DATAWIDTH-bit word as a valid/ready stream of bytes
module word_byte_serializer #(
    parameter int DATAWIDTH = 32,
    parameter bit MSB_FIRST = 1'b1,
    localparam int NBYTES = DATAWIDTH / 8,
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [IW-1:0]        out_idx,
    output logic                 busy
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nx;
    logic [DATAWIDTH-1:0] sreg;
    logic [IW-1:0] cnt, sel;
    logic xfer, last, accept;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                sreg <= in_data;
                cnt  <= '0;
            end else if (xfer && !last) begin
                cnt <= cnt + IW'(1);
            end
        end
    end
    always_comb begin
        busy      = (state == SEND);
        out_valid = busy;
        xfer      = out_valid & out_ready;
        last      = (cnt == IW'(NBYTES - 1));
        sel       = MSB_FIRST ? IW'(NBYTES - 1) - cnt : cnt;
        out_data  = busy ? sreg[{sel, 3'b000} +: 8] : 8'h00;
        out_idx   = busy ? cnt : '0;
        out_last  = busy & last;
        in_ready  = rst & (busy ? (xfer & last) : 1'b1);
        accept    = in_valid & in_ready;
        state_nx  = accept ? SEND : ((xfer && last) ? IDLE : state);
    end
endmodule

// File: tb/tb_word_byte_serializer.sv
// tb_word_byte_serializer: queue-based reference model checked against MSB, LSB and 8-bit instances
module tb_word_byte_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [31:0] d = '0;
    logic iv = 1'b0, ordy = 1'b0;
    logic [7:0] bd = '0;
    logic biv = 1'b0, bordy = 1'b0;
    logic m_ir, m_ov, m_last, m_busy, l_ir, l_ov, l_last, l_busy, b_ir, b_ov, b_last, b_busy;
    logic [7:0] m_od, l_od, b_od;
    logic [1:0] m_idx, l_idx;
    logic [0:0] b_idx;
    logic [7:0] qm[$], ql[$], qb[$];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    word_byte_serializer #(.DATAWIDTH(32), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_data(d), .in_valid(iv), .in_ready(m_ir),
        .out_data(m_od), .out_valid(m_ov), .out_ready(ordy), .out_last(m_last),
        .out_idx(m_idx), .busy(m_busy));
    word_byte_serializer #(.DATAWIDTH(32), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_data(d), .in_valid(iv), .in_ready(l_ir),
        .out_data(l_od), .out_valid(l_ov), .out_ready(ordy), .out_last(l_last),
        .out_idx(l_idx), .busy(l_busy));
    word_byte_serializer #(.DATAWIDTH(8), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_data(bd), .in_valid(biv), .in_ready(b_ir),
        .out_data(b_od), .out_valid(b_ov), .out_ready(bordy), .out_last(b_last),
        .out_idx(b_idx), .busy(b_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ir(input int n, input logic o);
        return rst && (n == 0 || (o && n == 1));
    endfunction

    task automatic port_chk(input string tag, input int n, input int nb, input logic [7:0] head,
                            input logic eir, input logic v, input logic [7:0] dat, input logic [31:0] idx,
                            input logic lst, input logic ir, input logic bz);
        chk({tag, ".valid"}, 32'(v), 32'(n > 0));
        chk({tag, ".data"}, 32'(dat), 32'(head));
        chk({tag, ".idx"}, idx, (n > 0) ? 32'(nb - n) : 32'd0);
        chk({tag, ".last"}, 32'(lst), 32'(n == 1));
        chk({tag, ".in_ready"}, 32'(ir), 32'(eir));
        chk({tag, ".busy"}, 32'(bz), 32'(n > 0));
    endtask

    task automatic cycle();
        int nm, nl, nb;
        logic irm, irl, irb;
        #1;
        nm = qm.size();
        nl = ql.size();
        nb = qb.size();
        irm = exp_ir(nm, ordy);
        irl = exp_ir(nl, ordy);
        irb = exp_ir(nb, bordy);
        port_chk("msb", nm, 4, nm > 0 ? qm[0] : 8'h00, irm, m_ov, m_od, 32'(m_idx), m_last, m_ir, m_busy);
        port_chk("lsb", nl, 4, nl > 0 ? ql[0] : 8'h00, irl, l_ov, l_od, 32'(l_idx), l_last, l_ir, l_busy);
        port_chk("w8", nb, 1, nb > 0 ? qb[0] : 8'h00, irb, b_ov, b_od, 32'(b_idx), b_last, b_ir, b_busy);
        if (!rst) begin
            qm.delete();
            ql.delete();
            qb.delete();
        end else begin
            if (nm > 0 && ordy) void'(qm.pop_front());
            if (nl > 0 && ordy) void'(ql.pop_front());
            if (nb > 0 && bordy) void'(qb.pop_front());
            if (iv && irm) for (int i = 3; i >= 0; i--) qm.push_back(d[8*i +: 8]);
            if (iv && irl) for (int i = 0; i < 4; i++) ql.push_back(d[8*i +: 8]);
            if (biv && irb) qb.push_back(bd);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        // MSB and LSB order of one word with free-flowing output
        iv = 1'b1; d = 32'h1234ABCD; ordy = 1'b1;
        biv = 1'b1; bd = 8'h5A; bordy = 1'b1;
        cycle();
        iv = 1'b0;
        bd = 8'hC3;
        cycle();
        biv = 1'b0;
        repeat (5) cycle();
        // stall on byte 1 while the producer changes in_data
        iv = 1'b1; d = 32'h1234ABCD;
        cycle();
        iv = 1'b0; d = '0;
        cycle();
        ordy = 1'b0;
        repeat (3) cycle();
        ordy = 1'b1;
        repeat (4) cycle();
        // back-to-back words with in_valid held
        iv = 1'b1; d = 32'h01020304;
        cycle();
        d = 32'hA0B0C0D0;
        repeat (4) cycle();
        iv = 1'b0;
        repeat (5) cycle();
        // asynchronous reset in the middle of a word
        iv = 1'b1; d = 32'hDEADBEEF;
        cycle();
        iv = 1'b0;
        cycle();
        rst = 1'b0;
        qm.delete();
        ql.delete();
        qb.delete();
        #1;
        chk("async.msb_valid", 32'(m_ov), 32'd0);
        chk("async.lsb_valid", 32'(l_ov), 32'd0);
        cycle();
        rst = 1'b1;
        cycle();
        for (int k = 0; k < 400; k++) begin
            iv = 1'($urandom_range(0, 1));
            d = $urandom;
            ordy = ($urandom_range(0, 3) != 0);
            biv = 1'($urandom_range(0, 1));
            bd = 8'($urandom);
            bordy = ($urandom_range(0, 3) != 0);
            cycle();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
